input_debouncer: RTL and testbench

//   Cleans a raw asynchronous input (push-button/switch) into a glitch-free level for the

---
 rtl/input_debouncer_if.sv | 23 ++
 rtl/input_debouncer.sv | 103 ++++++++++
 tb/tb_input_debouncer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - raw input and debounced status signals of input_debouncer
interface input_debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic                noisy_in;
  logic                level_out;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output noisy_in,
    input  level_out,
    input  busy,
    input  glitch_count
  );

  modport slave (
    input  noisy_in,
    output level_out,
    output busy,
    output glitch_count
  );
endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce a raw input, counting rejected glitches
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int GLITCH_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input_debouncer_if.slave   bus
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STABLE_LOW,
    ST_WAIT_HIGH,
    ST_STABLE_HIGH,
    ST_WAIT_LOW
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   level_q;
  logic                   busy_q;
  logic [GLITCH_W-1:0]    glitch_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  assign bus.level_out    = level_q;
  assign bus.busy         = busy_q;
  assign bus.glitch_count = glitch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state    <= ST_STABLE_LOW;
      cnt      <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.noisy_in};
      case (state)
        ST_STABLE_LOW: begin
          if (s) begin
            state  <= ST_WAIT_HIGH;
            cnt    <= CW'(1);
            busy_q <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          // Returning low, even on the final cycle, aborts the candidate as a glitch.
          if (!s) begin
            state  <= ST_STABLE_LOW;
            cnt    <= '0;
            busy_q <= 1'b0;
            if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
          end else if (cnt == LAST_CNT) begin
            state   <= ST_STABLE_HIGH;
            cnt     <= '0;
            busy_q  <= 1'b0;
            level_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STABLE_HIGH: begin
          if (!s) begin
            state  <= ST_WAIT_LOW;
            cnt    <= CW'(1);
            busy_q <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (s) begin
            state  <= ST_STABLE_HIGH;
            cnt    <= '0;
            busy_q <= 1'b0;
            if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
          end else if (cnt == LAST_CNT) begin
            state   <= ST_STABLE_LOW;
            cnt     <= '0;
            busy_q  <= 1'b0;
            level_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_STABLE_LOW;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  input_debouncer_if #(.GLITCH_W(8)) bus_a ();
  input_debouncer_if #(.GLITCH_W(2)) bus_b ();

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .GLITCH_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .GLITCH_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic lvl, input logic bsy, input int gc);
    check({tag, " level"}, 32'(bus_a.level_out), 32'(lvl));
    check({tag, " busy"}, 32'(bus_a.busy), 32'(bsy));
    check({tag, " glitch"}, 32'(bus_a.glitch_count), 32'(gc));
  endtask

  logic bounce [17];

  initial begin
    bus_a.noisy_in = 1'b1;
    bus_b.noisy_in = 1'b0;

    // 1: reset held two cycles with input high
    reset = 1'b1;
    step();
    step();
    check_a("reset", 1'b0, 1'b0, 0);
    check("reset b glitch", 32'(bus_b.glitch_count), 32'd0);
    reset = 1'b0;
    bus_a.noisy_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_a($sformatf("idle%0d", k), 1'b0, 1'b0, 0);
    end

    // 2: clean rise
    bus_a.noisy_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check_a($sformatf("rise e%0d", k), k >= 9, (k >= 2 && k <= 8), 0);
    end

    // 4: clean fall
    bus_a.noisy_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check_a($sformatf("fall e%0d", k), k < 9, (k >= 2 && k <= 8), 0);
    end

    // 3: bounce 1,0,1,1,0 then twelve highs
    bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b1; bounce[4] = 1'b0;
    for (int k = 5; k < 17; k++) bounce[k] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus_a.noisy_in = bounce[k];
      step();
      check($sformatf("bounce level e%0d", k), 32'(bus_a.level_out), 32'(k >= 14));
    end
    check("bounce glitch", 32'(bus_a.glitch_count), 32'd2);

    // 6: reset in the middle of a qualification
    bus_a.noisy_in = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check_a("pre mid", 1'b0, 1'b0, 0);
    bus_a.noisy_in = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check_a("mid busy", 1'b0, 1'b1, 0);
    reset = 1'b1;
    step();
    check_a("mid reset", 1'b0, 1'b0, 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_a($sformatf("post e%0d", k), k >= 9, (k >= 2 && k <= 8), 0);
    end

    // 5: glitch_count saturation on the 2-bit instance
    for (int g = 1; g <= 5; g++) begin
      bus_b.noisy_in = 1'b1;
      step();
      bus_b.noisy_in = 1'b0;
      for (int k = 0; k < 3; k++) step();
      check($sformatf("sat glitch g%0d", g), 32'(bus_b.glitch_count), 32'(g < 3 ? g : 3));
      check($sformatf("sat level g%0d", g), 32'(bus_b.level_out), 32'd0);
      check($sformatf("sat busy g%0d", g), 32'(bus_b.busy), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
